quad_motor_mixer: RTL and testbench

//  Downstream of the attitude PID stage, upstream of the four bb_pwm channel instances.

---
 rtl/drone_pkg.sv | 34 +++
 rtl/mix_saturate.sv | 78 +++++++
 rtl/quad_motor_mixer.sv | 229 ++++++++++++++++++++++
 tb/tb_quad_motor_mixer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drone_pkg.sv
// Shared types and constants for the quad motor mixer.
package drone_pkg;

    localparam int unsigned SPEED_W = 16;
    localparam int unsigned IN_W    = 16;
    localparam int unsigned MIX_W   = 19;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MIX  = 3'd1,
        SAT  = 3'd2,
        DISP = 3'd3,
        DONE = 3'd4
    } mixer_state_t;

    // X-frame sign table, {P,R,Y} per motor, 1 = subtract that correction
    localparam logic [2:0] SIGN_M1 = 3'b111;  // B-P-R-Y
    localparam logic [2:0] SIGN_M2 = 3'b100;  // B-P+R+Y
    localparam logic [2:0] SIGN_M3 = 3'b010;  // B+P-R+Y
    localparam logic [2:0] SIGN_M4 = 3'b001;  // B+P+R-Y

    localparam logic [11:0] SIGN_TABLE = {SIGN_M4, SIGN_M3, SIGN_M2, SIGN_M1};

    // Sign bits for motor index 0..3 (M1..M4)
    function automatic logic [2:0] motor_sign(input int unsigned m);
        return SIGN_TABLE[3*m +: 3];
    endfunction

    // Sign-extend a 16-bit correction into the mixing width
    function automatic logic signed [MIX_W-1:0] sext_corr(input logic [IN_W-1:0] c);
        return {{(MIX_W-IN_W){c[IN_W-1]}}, c};
    endfunction

endpackage

// File: rtl/mix_saturate.sv
// One motor lane: registered signed mix sum, then clamp into a registered speed word.
module mix_saturate #(
    parameter int unsigned OUT_W        = 16,
    parameter logic [2:0]  SIGN         = 3'b000,
    parameter int unsigned MAX_OUT      = 65535,
    parameter int unsigned MIN_OUT      = 256,
    parameter int unsigned FAILSAFE_OUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sum_en,
    input  logic              sat_en,
    input  logic [15:0]       base,
    input  logic [15:0]       corr_p,
    input  logic [15:0]       corr_r,
    input  logic [15:0]       corr_y,
    input  logic              armed,
    input  logic              force_fs,
    output logic [OUT_W-1:0]  speed
);
    import drone_pkg::*;

    localparam logic signed [MIX_W-1:0] MAX_S = MIX_W'(MAX_OUT);
    localparam logic signed [MIX_W-1:0] MIN_S = MIX_W'(MIN_OUT);

    logic signed [MIX_W-1:0] b_ext;
    logic signed [MIX_W-1:0] p_t;
    logic signed [MIX_W-1:0] r_t;
    logic signed [MIX_W-1:0] y_t;
    logic signed [MIX_W-1:0] sum_d;
    logic signed [MIX_W-1:0] sum_q;
    logic [OUT_W-1:0]        speed_d;
    logic [OUT_W-1:0]        speed_q;

    // Signed four-term mix, captured only while the FSM is in MIX
    always_comb begin
        b_ext = {{(MIX_W-IN_W){1'b0}}, base};
        p_t   = SIGN[2] ? -sext_corr(corr_p) : sext_corr(corr_p);
        r_t   = SIGN[1] ? -sext_corr(corr_r) : sext_corr(corr_r);
        y_t   = SIGN[0] ? -sext_corr(corr_y) : sext_corr(corr_y);
        sum_d = sum_q;
        if (sum_en) begin
            sum_d = b_ext + p_t + r_t + y_t;
        end
    end

    // Clamp/override, captured only while the FSM is in SAT
    always_comb begin
        speed_d = speed_q;
        if (sat_en) begin
            if (force_fs) begin
                speed_d = OUT_W'(FAILSAFE_OUT);
            end else if (!armed) begin
                speed_d = '0;
            end else if (sum_q > MAX_S) begin
                speed_d = OUT_W'(MAX_OUT);
            end else if (sum_q < MIN_S) begin
                speed_d = OUT_W'(MIN_OUT);
            end else begin
                speed_d = sum_q[OUT_W-1:0];
            end
        end
    end

    // Lane registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q   <= '0;
            speed_q <= '0;
        end else begin
            sum_q   <= sum_d;
            speed_q <= speed_d;
        end
    end

    assign speed = speed_q;

endmodule

// File: rtl/quad_motor_mixer.sv
// Quad X-frame mixer: frame accept, per-motor mix/clamp, PWM dispatch,
// arming follow-up frame and loss-of-command failsafe.
module quad_motor_mixer #(
    parameter int unsigned SPEED_W      = drone_pkg::SPEED_W,
    parameter int unsigned MAX_OUT      = 65535,
    parameter int unsigned MIN_OUT      = 256,
    parameter int unsigned FAILSAFE_OUT = 0,
    parameter int unsigned TIMEOUT_CYC  = 2500000,
    parameter int unsigned BUSY_TMO     = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 mix_valid,
    output logic                 mix_ready,
    input  logic [15:0]          base,
    input  logic [15:0]          corr_pitch,
    input  logic [15:0]          corr_roll,
    input  logic [15:0]          corr_yaw,
    output logic [4*SPEED_W-1:0] pwm_speed,
    output logic [3:0]           pwm_oe,
    input  logic [3:0]           pwm_busy,
    output logic                 frame_done,
    output logic                 failsafe,
    output logic                 overrun,
    output logic [3:0]           busy_fault
);
    import drone_pkg::*;

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BT_W = $clog2(BUSY_TMO + 1);

    mixer_state_t     state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [BT_W-1:0]  bt_q, bt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [15:0]      base_q, base_d;
    logic [15:0]      p_q, p_d;
    logic [15:0]      r_q, r_d;
    logic [15:0]      y_q, y_d;
    logic             armed_q, armed_d;
    logic             force_q, force_d;
    logic             failsafe_q, failsafe_d;
    logic             overrun_q, overrun_d;
    logic             disarm_pend_q, disarm_pend_d;
    logic             arm_prev_q, arm_prev_d;
    logic [3:0]       busy_fault_q, busy_fault_d;

    logic open_st;
    logic accept;
    logic wd_expired;
    logic arm_fall;
    logic advance;

    // Handshake and event decode
    always_comb begin
        // DONE doubles as an accept slot so mix_ready rises together with frame_done
        open_st    = (state_q == IDLE) || (state_q == DONE);
        mix_ready  = open_st && !disarm_pend_q;
        accept     = mix_valid && mix_ready;
        wd_expired = (wd_q == WD_W'(TIMEOUT_CYC));
        arm_fall   = arm_prev_q && !arm;
        frame_done = (state_q == DONE);
    end

    // Watchdog: runs only while armed, holds at expiry, cleared by an accepted frame
    always_comb begin
        wd_d = wd_q;
        if (accept) begin
            wd_d = '0;
        end else if (arm && !wd_expired) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    // Frame FSM, dispatch and sticky status flags
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        bt_d          = bt_q;
        base_d        = base_q;
        p_d           = p_q;
        r_d           = r_q;
        y_d           = y_q;
        armed_d       = armed_q;
        force_d       = force_q;
        failsafe_d    = failsafe_q;
        overrun_d     = overrun_q | (mix_valid & ~mix_ready);
        busy_fault_d  = busy_fault_q;
        disarm_pend_d = disarm_pend_q | arm_fall;
        arm_prev_d    = arm;
        pwm_oe        = '0;
        advance       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                // Self-issued frames take priority; a pending disarm also holds mix_ready low
                if (disarm_pend_q) begin
                    base_d        = '0;
                    p_d           = '0;
                    r_d           = '0;
                    y_d           = '0;
                    armed_d       = 1'b0;
                    force_d       = 1'b0;
                    disarm_pend_d = arm_fall;
                    state_d       = MIX;
                end else if (accept) begin
                    base_d     = base;
                    p_d        = corr_pitch;
                    r_d        = corr_roll;
                    y_d        = corr_yaw;
                    armed_d    = arm;
                    force_d    = 1'b0;
                    failsafe_d = 1'b0;
                    state_d    = MIX;
                end else if (wd_expired && !failsafe_q) begin
                    base_d     = '0;
                    p_d        = '0;
                    r_d        = '0;
                    y_d        = '0;
                    armed_d    = arm;
                    force_d    = 1'b1;
                    failsafe_d = 1'b1;
                    state_d    = MIX;
                end
            end
            MIX: begin
                state_d = SAT;
            end
            SAT: begin
                ch_d    = '0;
                bt_d    = '0;
                state_d = DISP;
            end
            DISP: begin
                if (!pwm_busy[ch_q]) begin
                    pwm_oe[ch_q] = 1'b1;
                    advance      = 1'b1;
                end else if (bt_q == BT_W'(BUSY_TMO - 1)) begin
                    busy_fault_d[ch_q] = 1'b1;
                    advance            = 1'b1;
                end else begin
                    bt_d = bt_q + BT_W'(1);
                end
                if (advance) begin
                    bt_d = '0;
                    if (ch_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        ch_d = ch_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The load strobe must not escape in the cycle reset aborts a frame
        if (reset) begin
            pwm_oe = '0;
        end
    end

    // Control and frame registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            bt_q          <= '0;
            wd_q          <= '0;
            base_q        <= '0;
            p_q           <= '0;
            r_q           <= '0;
            y_q           <= '0;
            armed_q       <= 1'b0;
            force_q       <= 1'b0;
            failsafe_q    <= 1'b0;
            overrun_q     <= 1'b0;
            disarm_pend_q <= 1'b0;
            arm_prev_q    <= 1'b0;
            busy_fault_q  <= '0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            bt_q          <= bt_d;
            wd_q          <= wd_d;
            base_q        <= base_d;
            p_q           <= p_d;
            r_q           <= r_d;
            y_q           <= y_d;
            armed_q       <= armed_d;
            force_q       <= force_d;
            failsafe_q    <= failsafe_d;
            overrun_q     <= overrun_d;
            disarm_pend_q <= disarm_pend_d;
            arm_prev_q    <= arm_prev_d;
            busy_fault_q  <= busy_fault_d;
        end
    end

    for (genvar m = 0; m < 4; m++) begin : g_motor
        mix_saturate #(
            .OUT_W        (SPEED_W),
            .SIGN         (motor_sign(m)),
            .MAX_OUT      (MAX_OUT),
            .MIN_OUT      (MIN_OUT),
            .FAILSAFE_OUT (FAILSAFE_OUT)
        ) u_mix (
            .clk      (clk),
            .reset    (reset),
            .sum_en   (state_q == MIX),
            .sat_en   (state_q == SAT),
            .base     (base_q),
            .corr_p   (p_q),
            .corr_r   (r_q),
            .corr_y   (y_q),
            .armed    (armed_q),
            .force_fs (force_q),
            .speed    (pwm_speed[m*SPEED_W +: SPEED_W])
        );
    end

    assign failsafe   = failsafe_q;
    assign overrun    = overrun_q;
    assign busy_fault = busy_fault_q;

endmodule

// File: tb/tb_quad_motor_mixer.sv
// Directed self-checking bench for quad_motor_mixer.
module tb_quad_motor_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        mix_valid;
    logic        mix_ready;
    logic [15:0] base, corr_pitch, corr_roll, corr_yaw;
    logic [63:0] pwm_speed;
    logic [3:0]  pwm_oe;
    logic [3:0]  pwm_busy;
    logic        frame_done;
    logic        failsafe;
    logic        overrun;
    logic [3:0]  busy_fault;

    int n_checks = 0;
    int n_errors = 0;

    int          oe_at [4];
    int          oe_cnt [4];
    int          done_at;
    int          done_cnt;
    logic        ready_at_done;
    logic [3:0]  oe_rst;
    logic        snap_ready, snap_ovr, snap_fs, snap_done;
    logic [63:0] snap_speed;
    logic [3:0]  snap_fault;

    quad_motor_mixer #(
        .TIMEOUT_CYC (300),
        .BUSY_TMO    (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .mix_valid  (mix_valid),
        .mix_ready  (mix_ready),
        .base       (base),
        .corr_pitch (corr_pitch),
        .corr_roll  (corr_roll),
        .corr_yaw   (corr_yaw),
        .pwm_speed  (pwm_speed),
        .pwm_oe     (pwm_oe),
        .pwm_busy   (pwm_busy),
        .frame_done (frame_done),
        .failsafe   (failsafe),
        .overrun    (overrun),
        .busy_fault (busy_fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] spd4(input int m1, input int m2, input int m3, input int m4);
        return {16'(m4), 16'(m3), 16'(m2), 16'(m1)};
    endfunction

    // Checks per-channel first-pulse offsets (-1 = never) and frame_done offset
    task automatic check_timing(input string tag, input int e0, input int e1, input int e2,
                                input int e3, input int edone);
        int exp_at [4];
        exp_at[0] = e0; exp_at[1] = e1; exp_at[2] = e2; exp_at[3] = e3;
        for (int c = 0; c < 4; c++) begin
            check_eq($sformatf("%s_oe%0d_at", tag, c), 64'(oe_at[c]), 64'(exp_at[c]));
            check_eq($sformatf("%s_oe%0d_cnt", tag, c), 64'(oe_cnt[c]), (exp_at[c] >= 0) ? 64'd1 : 64'd0);
        end
        check_eq({tag, "_done_at"}, 64'(done_at), 64'(edone));
        check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    endtask

    // Runs ncyc cycles starting at offset k=0 (current cycle), recording events
    task automatic watch(input int ncyc, input int busy_ch, input int busy_len,
                         input int inj_k, input int rst_k);
        for (int c = 0; c < 4; c++) begin
            oe_at[c]  = -1;
            oe_cnt[c] = 0;
        end
        done_at = -1; done_cnt = 0; ready_at_done = 1'b0; oe_rst = '0;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) mix_valid = 1'b0;
            if (k == inj_k) begin
                mix_valid = 1'b1; base = 16'd1234;
                corr_pitch = '0; corr_roll = '0; corr_yaw = '0;
            end
            reset    = (k == rst_k);
            pwm_busy = '0;
            if (busy_ch >= 0 && k < busy_len) pwm_busy[busy_ch] = 1'b1;
            #1;
            if (k == rst_k) oe_rst = pwm_oe;
            if (k == rst_k + 1) begin
                snap_ready = mix_ready; snap_speed = pwm_speed; snap_ovr = overrun;
                snap_fs = failsafe; snap_done = frame_done; snap_fault = busy_fault;
            end
            for (int c = 0; c < 4; c++) begin
                if (pwm_oe[c]) begin
                    oe_cnt[c]++;
                    if (oe_at[c] < 0) oe_at[c] = k;
                end
            end
            if (frame_done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    ready_at_done = mix_ready;
                end
            end
            @(posedge clk);
            #1;
        end
        mix_valid = 1'b0;
        reset     = 1'b0;
        pwm_busy  = '0;
    endtask

    task automatic send(input logic [15:0] b, input logic [15:0] p, input logic [15:0] r,
                        input logic [15:0] y, input int ncyc, input int busy_ch,
                        input int busy_len, input int inj_k, input int rst_k);
        int n = 0;
        while (!mix_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!mix_ready) check_eq("ready_wait", 64'(mix_ready), 64'd1);
        base = b; corr_pitch = p; corr_roll = r; corr_yaw = y;
        mix_valid = 1'b1;
        watch(ncyc, busy_ch, busy_len, inj_k, rst_k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int fs_at;
        int fd_cnt;
        int fd_at;

        reset = 1'b1; arm = 1'b0; mix_valid = 1'b0; pwm_busy = '0;
        base = '0; corr_pitch = '0; corr_roll = '0; corr_yaw = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("rst_ready", 64'(mix_ready), 64'd1);
        check_eq("rst_speed", pwm_speed, 64'd0);
        check_eq("rst_flags", 64'({pwm_oe, frame_done, failsafe, overrun, busy_fault}), 64'd0);
        @(posedge clk);
        #1;
        arm = 1'b1;

        // 1: nominal armed frame
        send(16'd30000, 16'd1000, 16'(-500), 16'd200, 20, -1, 0, -10, -10);
        check_eq("t1_speed", pwm_speed, spd4(29300, 28700, 31700, 30300));
        check_timing("t1", 3, 4, 5, 6, 7);
        check_eq("t1_ready_at_done", 64'(ready_at_done), 64'd1);

        // 2: upper clamp on M1
        send(16'd65000, 16'(-2000), 16'(-2000), 16'(-2000), 20, -1, 0, -10, -10);
        check_eq("t2_speed", pwm_speed, spd4(65535, 63000, 63000, 63000));

        // 3: idle-spin lower clamp
        send(16'd100, 16'd0, 16'd0, 16'd0, 20, -1, 0, -10, -10);
        check_eq("t3_speed", pwm_speed, spd4(256, 256, 256, 256));

        // 4: disarm issues a zero frame, then a disarmed frame gives zeros
        arm = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t4_ready_pend", 64'(mix_ready), 64'd0);
        watch(20, -1, 0, -10, -10);
        check_eq("t4_self_speed", pwm_speed, 64'd0);
        check_eq("t4_self_done_at", 64'(done_at), 64'd7);
        send(16'd30000, 16'd1000, 16'(-500), 16'd200, 20, -1, 0, -10, -10);
        check_eq("t4_disarm_speed", pwm_speed, 64'd0);
        check_eq("t4_disarm_done_at", 64'(done_at), 64'd7);

        // 5: channel 1 busy for the first 10 cycles
        arm = 1'b1;
        send(16'd30000, 16'd1000, 16'(-500), 16'd200, 30, 1, 10, -10, -10);
        check_timing("t5", 3, 10, 11, 12, 13);
        check_eq("t5_speed", pwm_speed, spd4(29300, 28700, 31700, 30300));
        check_eq("t5_fault", 64'(busy_fault), 64'd0);

        // 6: channel 2 stuck busy
        send(16'd65000, 16'(-2000), 16'(-2000), 16'(-2000), 40, 2, 1000, -10, -10);
        check_timing("t6", 3, 4, -1, 25, 26);
        check_eq("t6_fault", 64'(busy_fault), 64'b0100);

        // 7: command loss
        send(16'd30000, 16'd1000, 16'(-500), 16'd200, 10, -1, 0, -10, -10);
        check_eq("t7_pre_speed", pwm_speed, spd4(29300, 28700, 31700, 30300));
        fs_at = -1; fd_cnt = 0; fd_at = -1;
        for (int k = 10; k < 420; k++) begin
            if (failsafe && fs_at < 0) fs_at = k;
            if (frame_done) begin
                fd_cnt++;
                fd_at = k;
            end
            @(posedge clk);
            #1;
        end
        check_eq("t7_fs_at", 64'(fs_at), 64'd302);
        check_eq("t7_frames", 64'(fd_cnt), 64'd1);
        check_eq("t7_done_at", 64'(fd_at), 64'd308);
        check_eq("t7_speed", pwm_speed, 64'd0);
        check_eq("t7_fs_hold", 64'(failsafe), 64'd1);

        // 8: next frame clears failsafe
        send(16'd100, 16'd0, 16'd0, 16'd0, 12, -1, 0, -10, -10);
        check_eq("t8_fs", 64'(failsafe), 64'd0);
        check_eq("t8_speed", pwm_speed, spd4(256, 256, 256, 256));

        // 9: frame offered during DISP is dropped
        send(16'd30000, 16'd1000, 16'(-500), 16'd200, 20, -1, 0, 4, -10);
        check_eq("t9_overrun", 64'(overrun), 64'd1);
        check_eq("t9_done_cnt", 64'(done_cnt), 64'd1);
        check_eq("t9_speed", pwm_speed, spd4(29300, 28700, 31700, 30300));

        // 10: reset while dispatching channel 1
        send(16'd65000, 16'(-2000), 16'(-2000), 16'(-2000), 15, -1, 0, -10, 4);
        check_eq("t10_oe_in_reset", 64'(oe_rst), 64'd0);
        check_eq("t10_ready", 64'(snap_ready), 64'd1);
        check_eq("t10_speed", snap_speed, 64'd0);
        check_eq("t10_flags", 64'({snap_ovr, snap_fs, snap_done, snap_fault}), 64'd0);
        check_eq("t10_oe0_cnt", 64'(oe_cnt[0]), 64'd1);
        check_eq("t10_oe_rest", 64'(oe_cnt[1] + oe_cnt[2] + oe_cnt[3]), 64'd0);
        check_eq("t10_done_cnt", 64'(done_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
